// File: rtl/snail_pkg.sv
// Shared types and constants for the snail-sequence link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snail_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Frame marker, sent MSB-first ahead of every data word.
  localparam logic [2:0] PREAMBLE = 3'b110;
  localparam int         PRE_LEN  = 3;

  // Human-readable state names for waveform viewers and debug prints.
  function automatic string state_name(input state_t s);
    case (s)
      IDLE:    return "IDLE";
      PRE:     return "PRE";
      DATA:    return "DATA";
      GAP:     return "GAP";
      default: return "???";
    endcase
  endfunction

endpackage

// File: rtl/snail_seq_tx.sv
// Serial frame transmitter: preamble 110, W data bits MSB-first, GAP_LEN zero bits.
// Latency: first line bit appears 1 cycle after acceptance; frame spans 3+W+GAP_LEN cycles.
// Backpressure: ready only in IDLE; start while busy is dropped, nothing is queued.
import snail_pkg::*;

module snail_seq_tx #(
  parameter int W       = 8,
  parameter int GAP_LEN = 2
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic         ready,
  output logic         D,
  output logic         busy,
  output logic         done,
  output logic [7:0]   frame_cnt
);

  // The shared counter must reach the longest of the preamble, data and gap spans.
  localparam int SPAN_DG  = (W > GAP_LEN) ? W : GAP_LEN;
  localparam int SPAN     = (SPAN_DG > PRE_LEN) ? SPAN_DG : PRE_LEN;
  localparam int CW       = $clog2(SPAN) + 1;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);

  state_t        state;
  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;

  assign ready = (state == IDLE);
  assign busy  = !ready;

  // Frame sequencer: every output bit is registered on the transition into the cycle it belongs to.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      D         <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          D <= 1'b0;
          if (start) begin
            shreg <= data_in;
            cnt   <= '0;
            D     <= PREAMBLE[2];
            state <= PRE;
          end
        end
        PRE: begin
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            D     <= shreg[W-1];
            shreg <= shreg << 1;
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
            D   <= (cnt == '0) ? PREAMBLE[1] : PREAMBLE[0];
          end
        end
        DATA: begin
          if (cnt == DATA_LAST) begin
            cnt   <= '0;
            D     <= 1'b0;
            state <= GAP;
            // A one-bit gap is also the last gap cycle.
            if (GAP_LAST == '0) begin
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end
          end else begin
            cnt   <= cnt + CW'(1);
            D     <= shreg[W-1];
            shreg <= shreg << 1;
          end
        end
        GAP: begin
          D <= 1'b0;
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if ((cnt + CW'(1)) == GAP_LAST) begin
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          D     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snail_seq_tx.sv
// Self-checking bench for snail_seq_tx: a frame-offset reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_snail_seq_tx;

  localparam int W         = 8;
  localparam int GAP       = 2;
  localparam int FRAME_END = 3 + W + GAP;   // offset of the done cycle from acceptance

  logic         clk = 1'b0;
  logic         _rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready, D, busy, done;
  logic [7:0]   frame_cnt;

  snail_seq_tx #(.W(W), .GAP_LEN(GAP)) dut (
    .clk(clk), ._rst(_rst), .start(start), .data_in(data_in),
    .ready(ready), .D(D), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: position within the current frame ----------------
  int           off = -1;   // -1 idle, else cycles since acceptance
  logic [W-1:0] word;
  int           fcnt = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (_rst) begin
      if (off >= 0) begin
        off++;
        if (off > FRAME_END) off = -1;
        if (off == FRAME_END) fcnt = (fcnt + 1) % 256;
      end else if (start) begin
        off  = 1;
        word = data_in;
      end
    end
  end

  always @(negedge _rst) begin
    off  = -1;
    fcnt = 0;
  end

  function automatic logic exp_d(input int o);
    if (o >= 1 && o <= 3) return (o != 3);
    if (o >= 4 && o <= 3 + W) return word[W-1-(o-4)];
    return 1'b0;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic er;
    er = (off < 0);
    chk("outputs{D,ready,busy,done,frame_cnt}",
        {20'd0, D, ready, busy, done, frame_cnt},
        {20'd0, exp_d(off), er, !er, (off == FRAME_END), 8'(fcnt)});
  end

  // ---------------- observers: done pulses, acceptances, 110 detector ----------------
  int   done_cnt = 0;
  int   acc_q[$];
  int   hits = 0;
  int   hit_off = -1;
  logic [2:0] hist = 3'b000;
  logic prev_rdy = 1'b1;

  always @(negedge clk) begin
    if (!_rst) begin
      hist     = 3'b000;
      prev_rdy = 1'b1;
    end else begin
      if (done) done_cnt++;
      if (prev_rdy && busy) acc_q.push_back(cyc);
      prev_rdy = ready;
      hist = {hist[1:0], D};
      if (hist == 3'b110) begin
        hits++;
        hit_off = off;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      go();
      n++;
    end
    if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic send_cap(input logic [W-1:0] d, output logic [12:0] bits, output logic [12:0] dn);
    wait_ready();
    start   = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = W'($urandom);
    bits = '0;
    dn   = '0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bits = {bits[11:0], D};
      dn   = {dn[11:0], done};
    end
    go();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [12:0] bits, dn;
    int dc, n;

    // Reset values
    #1 _rst = 1'b0;
    repeat (3) go();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_D", {31'd0, D}, 32'd0);
    _rst = 1'b1;
    @(negedge clk);
    chk("post_rst_vals", {27'd0, ready, D, busy, done, 1'b0}, {27'd0, 5'b10000});
    chk("post_rst_cnt", {24'd0, frame_cnt}, 32'd0);
    go();

    // Single frame 0xA5 with loopback detector
    hits = 0;
    hit_off = -1;
    send_cap(8'hA5, bits, dn);
    chk("a5_line", {19'd0, bits}, {19'd0, 13'b1101010010100});
    chk("a5_done", {19'd0, dn}, {19'd0, 13'b0000000000001});
    chk("a5_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("a5_ready_after", {31'd0, ready}, 32'd1);
    chk("loop_hits", hits, 32'd1);
    chk("loop_hit_offset", hit_off, 32'd3);

    // Back-to-back with start held, data changed mid-frame
    wait_ready();
    acc_q.delete();
    start   = 1'b1;
    data_in = 8'hFF;
    n = 0;
    while (acc_q.size() < 1 && n < 50) begin go(); n++; end
    data_in = 8'h00;
    n = 0;
    while (acc_q.size() < 2 && n < 50) begin go(); n++; end
    start = 1'b0;
    chk("b2b_accepts", acc_q.size(), 32'd2);
    if (acc_q.size() >= 2) chk("b2b_period", acc_q[1] - acc_q[0], 32'd14);
    wait_ready();

    // Reset in the 4th data bit
    start   = 1'b1;
    data_in = 8'h5A;
    go();
    start = 1'b0;
    repeat (6) go();
    dc = done_cnt;
    _rst = 1'b0;
    #1;
    chk("midrst_D", {31'd0, D}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    go();
    _rst = 1'b1;
    repeat (20) go();
    chk("midrst_no_done", done_cnt - dc, 32'd0);
    send_cap(8'h3C, bits, dn);
    chk("3c_line", {19'd0, bits}, {19'd0, 13'b1100011110000});
    chk("3c_done", {19'd0, dn}, {19'd0, 13'b0000000000001});

    // 256 frames: frame_cnt wraps back to 0
    _rst = 1'b0;
    go();
    _rst = 1'b1;
    go();
    acc_q.delete();
    dc = done_cnt;
    start = 1'b1;
    n = 0;
    while (acc_q.size() < 256 && n < 5000) begin
      data_in = W'($urandom);
      go();
      n++;
    end
    start = 1'b0;
    wait_ready();
    chk("wrap_done_pulses", done_cnt - dc, 32'd256);
    chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        _rst = 1'b0;
        go();
        _rst = 1'b1;
      end
      go();
    end
    start = 1'b0;
    wait_ready();

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
